// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcodes, flag indices, 16-bit op encoding and sequencer state encoding
package alu_pkg;
  localparam logic [5:0] ALU_ADD = 6'd0;
  localparam logic [5:0] ALU_ADC = 6'd1;
  localparam logic [5:0] ALU_SUB = 6'd2;
  localparam logic [5:0] ALU_SBC = 6'd3;
  localparam int F_Z = 3;
  localparam int F_N = 2;
  localparam int F_H = 1;
  localparam int F_C = 0;
  typedef enum logic [1:0] {OP16_ADD16, OP16_ADDSP, OP16_INC16, OP16_DEC16} op16_t;
  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI} state_t;
endpackage

// File: rtl/alu8.sv
// alu8: shared 8-bit ALU (ADD/ADC/SUB/SBC); C is carry for adds and borrow for subtracts
module alu8
  import alu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [5:0] op,
  input  logic [3:0] flags_in,
  output logic [7:0] result,
  output logic [3:0] flags_out
);
  logic sub, cin;
  logic [8:0] s;
  logic [4:0] h;
  always_comb begin
    sub = (op == ALU_SUB) || (op == ALU_SBC);
    cin = ((op == ALU_ADC) || (op == ALU_SBC)) && flags_in[F_C];
    s = sub ? {1'b0, a} - {1'b0, b} - 9'(cin) : {1'b0, a} + {1'b0, b} + 9'(cin);
    h = sub ? {1'b0, a[3:0]} - {1'b0, b[3:0]} - 5'(cin) : {1'b0, a[3:0]} + {1'b0, b[3:0]} + 5'(cin);
    result = s[7:0];
    flags_out = {s[7:0] == 8'h00, sub, h[4], s[8]};
  end
endmodule

// File: rtl/alu16_seq.sv
// alu16_seq: 16-bit ADD/ADDSP/INC/DEC done as two passes through the shared 8-bit ALU
module alu16_seq
  import alu_pkg::*;
#(
  parameter int ALU_OP_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [15:0]         opa,
  input  logic [15:0]         opb,
  input  logic [3:0]          flags_in,
  output logic                busy,
  output logic                done,
  output logic [15:0]         result,
  output logic [3:0]          flags_out,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [3:0]          alu_flags_in,
  input  logic [7:0]          alu_result,
  input  logic [3:0]          alu_flags_out
);
  state_t state, state_nxt;
  logic [1:0] op_q;
  logic [15:0] a_q, b_q;
  logic [3:0] f_q, f_lo, f_hi;
  logic [7:0] res_lo, b_lo, b_hi;
  logic lo, hi, is_add, is_sub;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = start ? S_LO : S_IDLE;
      S_LO:   state_nxt = S_HI;
      default: state_nxt = S_IDLE;
    endcase
  end
  always_comb begin
    lo = state == S_LO;
    hi = state == S_HI;
    is_add = (op_q == OP16_ADD16) || (op_q == OP16_ADDSP);
    is_sub = op_q == OP16_DEC16;
    b_lo = is_add ? b_q[7:0] : 8'h01;
    b_hi = (op_q == OP16_ADD16) ? b_q[15:8] : (op_q == OP16_ADDSP) ? {8{b_q[7]}} : 8'h00;
    alu_a = lo ? a_q[7:0] : hi ? a_q[15:8] : 8'h00;
    alu_b = lo ? b_lo : hi ? b_hi : 8'h00;
    alu_op = lo ? ALU_OP_W'(is_sub ? ALU_SUB : ALU_ADD) :
             hi ? ALU_OP_W'(is_sub ? ALU_SBC : ALU_ADC) : ALU_OP_W'(ALU_ADD);
    alu_flags_in = hi ? {3'b000, f_lo[F_C]} : 4'h0;
    // ADDSP flags come from the low pass (bit-3/bit-7 carries), ADD16 from the high pass
    f_hi = (op_q == OP16_ADD16) ? {f_q[F_Z], 1'b0, alu_flags_out[F_H], alu_flags_out[F_C]} :
           (op_q == OP16_ADDSP) ? {2'b00, f_lo[F_H], f_lo[F_C]} : f_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_q <= 2'd0;
      a_q <= 16'h0;
      b_q <= 16'h0;
      f_q <= 4'h0;
      res_lo <= 8'h0;
      f_lo <= 4'h0;
      result <= 16'h0;
      flags_out <= 4'h0;
      done <= 1'b0;
    end else begin
      done <= hi;
      if (state == S_IDLE && start) begin
        op_q <= op;
        a_q <= opa;
        b_q <= opb;
        f_q <= flags_in;
      end
      if (lo) begin
        res_lo <= alu_result;
        f_lo <= alu_flags_out;
      end
      if (hi) begin
        result <= {alu_result, res_lo};
        flags_out <= f_hi;
      end
    end
  assign busy = state != S_IDLE;
endmodule

// File: doc/alu16_seq.md
Name: alu16_seq

Overview:
- Multi-cycle sequencer that performs the CPU's 16-bit arithmetic (ADD HL,rr; ADD SP,e8 / LD HL,SP+e8; INC rr; DEC rr) by driving the shared 8-bit ALU twice: low byte, then high byte with carry.
- It is the initiator side of the 8-bit ALU interface. It drives alu_a/alu_b/alu_op/alu_flags_in and consumes alu_result/alu_flags_out combinationally in the same cycle.
- Sits in the CPU datapath between the control unit (start/op handshake) and the ALU instance.

Parameters:
- ALU_OP_W, 6, width of the ALU opcode bus.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only when busy=0
- op  in  2  0=ADD16, 1=ADDSP, 2=INC16, 3=DEC16
- opa  in  16  first operand (HL, SP or rr)
- opb  in  16  second operand; for ADDSP only opb[7:0] (signed e8) is used; ignored for INC16/DEC16
- flags_in  in  4  current CPU flags {Z,N,H,C} = bits [3:0]
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse; result/flags_out valid while high
- result  out  16  16-bit result, held until the next done
- flags_out  out  4  resulting {Z,N,H,C}, held until the next done
- alu_a  out  8  to ALU
- alu_b  out  8  to ALU
- alu_op  out  ALU_OP_W  to ALU
- alu_flags_in  out  4  to ALU
- alu_result  in  8  from ALU
- alu_flags_out  in  4  from ALU

Behaviour:
- Reset (rst_n=0, async): state=IDLE, busy=0, done=0, result=0, flags_out=0, all internal operand/partial registers=0. This applies mid-operation too; the in-flight operation is discarded with no done.
- ALU opcodes (shared package): ALU_ADD=0, ALU_ADC=1, ALU_SUB=2, ALU_SBC=3. The ALU's C is carry for ADD/ADC and borrow for SUB/SBC.
- FSM states: IDLE, LO, HI.
  - IDLE: if start=1, latch op/opa/opb/flags_in and go to LO; otherwise stay.
  - LO: drive the low pass, register alu_result as res_lo and alu_flags_out as f_lo, go to HI.
  - HI: drive the high pass, register {alu_result,res_lo} into result, compute flags_out, pulse done, go to IDLE.
- busy = (state != IDLE), decoded from registered state.
- done is registered: high for exactly the one cycle after HI.
- Latency: start sampled at edge k gives done=1 during the cycle after edge k+2. A start in the done cycle is accepted (back-to-back, 3-cycle throughput).
- start while busy=1 is ignored, not queued.
- ALU drive per state (alu_flags_in in HI = {3'b000, f_lo[0]}):
  - IDLE: a=0, b=0, op=ALU_ADD, flags_in=0.
  - ADD16: LO a=opa[7:0], b=opb[7:0], ALU_ADD; HI a=opa[15:8], b=opb[15:8], ALU_ADC.
  - ADDSP: LO a=opa[7:0], b=opb[7:0], ALU_ADD; HI a=opa[15:8], b={8{opb[7]}}, ALU_ADC.
  - INC16: LO b=0x01, ALU_ADD; HI b=0x00, ALU_ADC.
  - DEC16: LO b=0x01, ALU_SUB; HI b=0x00, ALU_SBC.
- flags_out:
  - ADD16: Z=latched flags_in Z, N=0, H=HI-pass H (bit-11 carry), C=HI-pass C.
  - ADDSP: Z=0, N=0, H=f_lo H (bit-3 carry), C=f_lo C (bit-7 carry).
  - INC16/DEC16: flags_out = latched flags_in, unchanged.
- Operands are latched at accept. Changes on opa/opb/flags_in while busy have no effect.

Decomposition:
- Shared package alu_pkg holds:
  - ALU opcode constants (ALU_ADD..ALU_SBC).
  - Flag bit indices (F_Z=3, F_N=2, F_H=1, F_C=0).
  - 16-bit op encoding (OP16_ADD16..OP16_DEC16).
  - FSM state encoding.
- No sub-module. The ALU is instantiated beside this block by the parent, not inside it. The bench instantiates the real ALU to close the loop.

Test Plan:
- ADD16 opa=0x0FFF, opb=0x0001, flags_in=0x8 -> result=0x1000, flags_out=0xA (Z kept, H=1); done exactly 2 cycles after start edge; busy high for 2 cycles.
- ADD16 opa=0xFFFF, opb=0x0001, flags_in=0x0 -> result=0x0000, flags_out=0x3 (Z not set).
- ADDSP opa=0x0005, opb=0x00FE (e8=-2) -> result=0x0003, flags_out=0x3; ADDSP opa=0x1000, opb=0x0080 -> result=0x0F80, flags_out=0x0.
- DEC16 opa=0x0000, flags_in=0xF -> result=0xFFFF, flags_out=0xF; INC16 opa=0x00FF, flags_in=0x4 -> result=0x0100, flags_out=0x4.
- Two operations issued back-to-back (start held high through the done cycle); extra start pulses while busy -> exactly two done pulses, each with the correct result.
- rst_n asserted during LO -> busy, done, result and flags_out all 0 immediately. After release, IDLE stays quiet, and a fresh ADD16 0x1234+0x1111 gives 0x2345.
